// File: rtl/frame_timing_generator_prog.sv
// frame_timing_generator_prog: programmable fval/lval/dval frame timing with multi-pixel beats,
// per-frame latched geometry, enforced frame period, overrun/config error flags and frame counter.
module frame_timing_generator_prog #(
  parameter int PPC        = 1,
  parameter int MAX_WIDTH  = 4096,
  parameter int MAX_HEIGHT = 4096,
  parameter int TW         = 16,
  parameter int PW         = 32,
  parameter int XW         = $clog2(MAX_WIDTH+1),
  parameter int YW         = $clog2(MAX_HEIGHT+1)
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           en,
  input  logic           cont,
  input  logic [XW-1:0]  cfg_width,
  input  logic [YW-1:0]  cfg_height,
  input  logic [TW-1:0]  cfg_t_vb,
  input  logic [TW-1:0]  cfg_t_lb,
  input  logic [TW-1:0]  cfg_t_ls,
  input  logic [TW-1:0]  cfg_t_lh,
  input  logic [PW-1:0]  cfg_period,
  input  logic           clr_err,
  output logic           fval,
  output logic           lval,
  output logic           dval,
  output logic [PPC-1:0] lane_mask,
  output logic [XW-1:0]  pix,
  output logic [YW-1:0]  line,
  output logic           sof,
  output logic           eof,
  output logic [15:0]    frame_cnt,
  output logic           busy,
  output logic           overrun,
  output logic           cfg_err
);
  localparam int CW = TW > XW ? TW : XW;
  localparam int SH = $clog2(PPC);
  typedef enum logic [2:0] {IDLE, VBLANK, LBLANK, LSETUP, ACTIVE, LHOLD, FTAIL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim, vb_q, lb_q, ls_q, lh_q, bl_q;
  logic [PW-1:0] pc_q, pc_d, per_q;
  logic [PW:0] pc1;
  logic [YW-1:0] line_q, line_d, hl_q;
  logic [XW-1:0] pix_q, pix_d, wm1;
  logic [PPC-1:0] lm_last_q, lm_n, lm_d, ones;
  logic [15:0] fc_q, fc_d;
  logic fval_q, lval_q, dval_q, sof_q, eof_q, busy_q, ovr_q, cerr_q;
  logic fval_d, lval_d, dval_d, sof_d, eof_d, busy_d, ovr_d, cerr_d;
  logic last, done, start_req, bad, go;
  // Blanking fields are stored as terminal counts so a zero field still yields one cycle.
  function automatic logic [CW-1:0] lastc(input logic [TW-1:0] t);
    return (t == '0) ? '0 : CW'(t - TW'(1));
  endfunction
  assign ones      = '1;
  assign wm1       = cfg_width - XW'(1);
  assign lm_n      = ones >> (XW'(PPC-1) - (wm1 & XW'(PPC-1)));
  assign pc1       = {1'b0, pc_q} + (PW+1)'(1);
  assign done      = pc1 >= {1'b0, per_q};
  assign start_req = en && (state_q == IDLE || (state_q == FTAIL && done && cont));
  assign bad       = cfg_width == '0 || cfg_height == '0;
  assign go        = start_req && !bad;
  assign lim       = state_q == VBLANK ? vb_q : state_q == LBLANK ? lb_q :
                     state_q == LSETUP ? ls_q : state_q == ACTIVE ? bl_q : lh_q;
  assign last      = cnt_q == lim;
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE:    state_d = go ? VBLANK : IDLE;
      VBLANK:  if (last) begin state_d = LBLANK; line_d = '0; end
      LBLANK:  if (last) state_d = LSETUP;
      LSETUP:  if (last) begin state_d = ACTIVE; pix_d = '0; end
      ACTIVE:  if (last) state_d = LHOLD; else pix_d = pix_q + XW'(PPC);
      LHOLD:   if (last) begin
        state_d = (line_q == hl_q) ? FTAIL : LBLANK;
        line_d  = (line_q == hl_q) ? line_q : line_q + YW'(1);
      end
      FTAIL:   if (done) state_d = go ? VBLANK : IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + CW'(1) : '0;
    pc_d  = go ? '0 : (state_q == IDLE ? pc_q : pc_q + PW'(1));
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  assign fval_d = state_d inside {LBLANK, LSETUP, ACTIVE, LHOLD};
  assign lval_d = state_d inside {LSETUP, ACTIVE, LHOLD};
  assign dval_d = state_d == ACTIVE;
  assign lm_d   = !dval_d ? '0 : (cnt_d == bl_q) ? lm_last_q : ones;
  assign sof_d  = state_q == VBLANK && state_d == LBLANK;
  assign eof_d  = state_d == FTAIL && state_q != FTAIL;
  assign busy_d = state_d != IDLE;
  assign fc_d   = fc_q + 16'(state_q == FTAIL && done);
  assign ovr_d  = (state_q == FTAIL && eof_q && pc1 > {1'b0, per_q}) || (ovr_q && !clr_err);
  assign cerr_d = (start_req && bad) || (cerr_q && !clr_err);
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pc_q <= '0;
      line_q <= '0;
      pix_q <= '0;
      vb_q <= '0;
      lb_q <= '0;
      ls_q <= '0;
      lh_q <= '0;
      bl_q <= '0;
      hl_q <= '0;
      per_q <= '0;
      lm_last_q <= '0;
      fc_q <= '0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      dval_q <= 1'b0;
      lane_mask <= '0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      busy_q <= 1'b0;
      ovr_q <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      line_q <= line_d;
      pix_q <= pix_d;
      if (go) begin
        vb_q <= lastc(cfg_t_vb);
        lb_q <= lastc(cfg_t_lb);
        ls_q <= lastc(cfg_t_ls);
        lh_q <= lastc(cfg_t_lh);
        bl_q <= CW'(wm1 >> SH);
        hl_q <= cfg_height - YW'(1);
        per_q <= cfg_period;
        lm_last_q <= lm_n;
      end
      fc_q <= fc_d;
      fval_q <= fval_d;
      lval_q <= lval_d;
      dval_q <= dval_d;
      lane_mask <= lm_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
      cerr_q <= cerr_d;
    end
  end
  assign fval      = fval_q;
  assign lval      = lval_q;
  assign dval      = dval_q;
  assign pix       = pix_q;
  assign line      = line_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign frame_cnt = fc_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;
  assign cfg_err   = cerr_q;
endmodule
